// File: rtl/sos_cascade_sched_if.sv
// Sample stream bundle for the SOS cascade scheduler: input sample handshake
// and filtered output handshake.
interface sos_cascade_sched_if #(
    parameter int DW = 24
);
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;

    modport master (output s_valid, s_data, m_ready, input s_ready, m_valid, m_data);
    modport slave  (input s_valid, s_data, m_ready, output s_ready, m_valid, m_data);
endinterface

// File: rtl/sos_cascade_sched.sv
// Time-multiplexed biquad cascade scheduler with double-buffered coefficient bank.
// Optional engine-response timeout: define SOS_SCHED_TIMEOUT_EN.
module sos_cascade_sched #(
    parameter int NUM_SEC = 4,
    parameter int DW      = 24,
    parameter int TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    sos_cascade_sched_if.slave  strm,
    input  logic                cfg_we,
    input  logic [2:0]          cfg_sec,
    input  logic [2:0]          cfg_sel,
    input  logic [DW-1:0]       cfg_data,
    input  logic                cfg_commit,
    output logic                eng_valid_in,
    output logic [DW-1:0]       eng_data_in,
    output logic [2:0]          eng_sec,
    output logic [DW-1:0]       eng_b0,
    output logic [DW-1:0]       eng_b1,
    output logic [DW-1:0]       eng_b2,
    output logic [DW-1:0]       eng_a1,
    output logic [DW-1:0]       eng_a2,
    input  logic                eng_valid_out,
    input  logic [DW-1:0]       eng_data_out,
    output logic                busy,
    output logic                err,
    input  logic                err_clr
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam logic [DW-1:0]        ONE  = DW'(1) << (DW - 2);
    localparam logic [4:0][DW-1:0]   PASS = {{(4 * DW){1'b0}}, ONE};

    state_t        state_reg, state_next;
    logic [2:0]    idx_reg, idx_next;
    logic [DW-1:0] sample_reg, sample_next;
    logic          pending_reg;
    logic          copy;

    // Padded to 8 sections so the 3-bit section index always addresses a full bank.
    logic [7:0][4:0][DW-1:0] act_bank;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_sec
            if (gi < NUM_SEC) begin : g_live
                logic [4:0][DW-1:0] shadow_reg;
                logic [4:0][DW-1:0] active_reg;

                always_ff @(posedge clk) begin
                    if (rst) begin
                        shadow_reg <= PASS;
                        active_reg <= PASS;
                    end else begin
                        if (copy)
                            active_reg <= shadow_reg;
                        if (cfg_we && cfg_sec == 3'(gi) && cfg_sel <= 3'd4)
                            shadow_reg[cfg_sel] <= cfg_data;
                    end
                end
                assign act_bank[gi] = active_reg;
            end else begin : g_unused
                assign act_bank[gi] = PASS;
            end
        end
    endgenerate

`ifdef SOS_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          timeout;
    logic          err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            cnt_reg <= cnt_next;
            // A timeout wins over a simultaneous clear.
            if (timeout)
                err_reg <= 1'b1;
            else if (err_clr)
                err_reg <= 1'b0;
        end
    end
    assign err = err_reg;
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT) ^ {31'b0, err_clr};
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            idx_reg     <= 3'd0;
            sample_reg  <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            idx_reg    <= idx_next;
            sample_reg <= sample_next;
            if (cfg_commit)
                pending_reg <= 1'b1;
            else if (copy)
                pending_reg <= 1'b0;
        end
    end

    always_comb begin
        state_next  = state_reg;
        idx_next    = idx_reg;
        sample_next = sample_reg;
        copy        = 1'b0;
`ifdef SOS_SCHED_TIMEOUT_EN
        cnt_next    = cnt_reg;
        timeout     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    copy = 1'b1;
                end else if (strm.s_valid) begin
                    sample_next = strm.s_data;
                    idx_next    = 3'd0;
                    state_next  = ISSUE;
                end
            end
            ISSUE: begin
                state_next = WAIT;
`ifdef SOS_SCHED_TIMEOUT_EN
                cnt_next   = '0;
`endif
            end
            WAIT: begin
                if (eng_valid_out) begin
                    sample_next = eng_data_out;
                    if (idx_reg == 3'(NUM_SEC - 1)) begin
                        state_next = OUT;
                    end else begin
                        idx_next   = idx_reg + 3'd1;
                        state_next = ISSUE;
                    end
                end else begin
`ifdef SOS_SCHED_TIMEOUT_EN
                    if (cnt_reg == CW'(TIMEOUT - 1)) begin
                        timeout    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        cnt_next = cnt_reg + 1'b1;
                    end
`endif
                end
            end
            OUT: begin
                if (strm.m_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign strm.s_ready = (state_reg == IDLE) && !pending_reg;
    assign strm.m_valid = (state_reg == OUT);
    assign strm.m_data  = sample_reg;
    assign eng_valid_in = (state_reg == ISSUE);
    assign eng_data_in  = sample_reg;
    assign eng_sec      = idx_reg;
    assign eng_b0       = act_bank[idx_reg][0];
    assign eng_b1       = act_bank[idx_reg][1];
    assign eng_b2       = act_bank[idx_reg][2];
    assign eng_a1       = act_bank[idx_reg][3];
    assign eng_a2       = act_bank[idx_reg][4];
    assign busy         = (state_reg != IDLE);
endmodule

// File: tb/tb_sos_cascade_sched.sv
// Scoreboard bench for sos_cascade_sched: engine model y = b0*x (Q2.22), L=2,
// directed samples with hand-computed outputs checked by a decoupled monitor.
module tb_sos_cascade_sched;
    localparam int DW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we, cfg_commit, err_clr;
    logic [2:0]    cfg_sec, cfg_sel;
    logic [DW-1:0] cfg_data;
    logic          eng_valid_in, eng_valid_out;
    logic [DW-1:0] eng_data_in, eng_data_out;
    logic [2:0]    eng_sec;
    logic [DW-1:0] eng_b0, eng_b1, eng_b2, eng_a1, eng_a2;
    logic          busy, err;

    sos_cascade_sched_if #(.DW(DW)) sif ();

    sos_cascade_sched #(.NUM_SEC(4), .DW(DW), .TIMEOUT(15)) dut (
        .clk(clk), .rst(rst), .strm(sif),
        .cfg_we(cfg_we), .cfg_sec(cfg_sec), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_commit(cfg_commit),
        .eng_valid_in(eng_valid_in), .eng_data_in(eng_data_in), .eng_sec(eng_sec),
        .eng_b0(eng_b0), .eng_b1(eng_b1), .eng_b2(eng_b2), .eng_a1(eng_a1), .eng_a2(eng_a2),
        .eng_valid_out(eng_valid_out), .eng_data_out(eng_data_out),
        .busy(busy), .err(err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic [2:0]    sec_q[$];
    logic          eng_on = 1'b1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic bound_fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
    endtask

    // Engine model: result visible L=2 cycles after the issue cycle; flushed by rst.
    initial begin : engine
        logic               c_v, c_rst, p_v;
        logic [DW-1:0]      c_d, p_d;
        logic signed [47:0] prod;
        eng_valid_out = 1'b0;
        eng_data_out  = '0;
        p_v = 1'b0;
        p_d = '0;
        forever begin
            @(negedge clk);
            c_v   = eng_valid_in && eng_on && !rst;
            c_rst = rst;
            prod  = $signed(eng_b0) * $signed(eng_data_in);
            c_d   = prod[45:22];
            @(posedge clk);
            #1;
            if (c_rst) begin
                eng_valid_out = 1'b0;
                p_v = 1'b0;
            end else begin
                eng_valid_out = p_v;
                eng_data_out  = p_d;
                p_v = c_v;
                p_d = c_d;
            end
        end
    end

    // Monitor: pops expected output samples and section indices as the DUT presents them.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (!rst && sif.m_valid && sif.m_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL out_unexpected: got m_data %0h required no output", sif.m_data);
                end else begin
                    check("out_m_data", 32'(sif.m_data), 32'(exp_q.pop_front()));
                end
            end
            if (!rst && eng_valid_in) begin
                if (sec_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL issue_unexpected: got eng_sec %0d required no issue", eng_sec);
                end else begin
                    check("issue_eng_sec", 32'(eng_sec), 32'(sec_q.pop_front()));
                end
            end
        end
    end

    task automatic push_secs(input int n);
        for (int i = 0; i < n; i++) sec_q.push_back(3'(i));
    endtask

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic send(input logic [DW-1:0] x, output int t);
        t = -1;
        sif.s_valid = 1'b1;
        sif.s_data  = x;
        for (int i = 0; i < 200 && t < 0; i++) begin
            @(negedge clk);
            if (sif.s_ready) t = cyc;
            @(posedge clk);
            #1;
        end
        sif.s_valid = 1'b0;
        if (t < 0) bound_fail("send");
    endtask

    task automatic wait_mvalid(output int c);
        c = -1;
        for (int i = 0; i < 200 && c < 0; i++) begin
            @(negedge clk);
            if (sif.m_valid) c = cyc;
            @(posedge clk);
            #1;
        end
        if (c < 0) bound_fail("wait_mvalid");
    endtask

    task automatic wait_issue(input logic [2:0] sec);
        int found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (eng_valid_in && eng_sec == sec) found = 1;
            @(posedge clk);
            #1;
        end
        if (found == 0) bound_fail("wait_issue");
    endtask

    task automatic wait_idle();
        int found = 0;
        for (int i = 0; i < 200 && found == 0; i++) begin
            @(negedge clk);
            if (!busy) found = 1;
            @(posedge clk);
            #1;
        end
        if (found == 0) bound_fail("wait_idle");
    endtask

    task automatic cfg_write(input logic [2:0] sec, input logic [2:0] sel, input logic [DW-1:0] d);
        cfg_we   = 1'b1;
        cfg_sec  = sec;
        cfg_sel  = sel;
        cfg_data = d;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic pulse_commit();
        cfg_commit = 1'b1;
        @(posedge clk);
        #1;
        cfg_commit = 1'b0;
    endtask

    initial begin : stimulus
        int t, c;
        rst = 1'b1;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.m_ready = 1'b1;
        cfg_we = 1'b0; cfg_commit = 1'b0; err_clr = 1'b0;
        cfg_sec = '0; cfg_sel = '0; cfg_data = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_s_ready", 32'(sif.s_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_m_valid", 32'(sif.m_valid), 32'd0);
        check("rst_m_data", 32'(sif.m_data), 32'd0);
        check("rst_eng_valid_in", 32'(eng_valid_in), 32'd0);
        check("rst_eng_sec", 32'(eng_sec), 32'd0);
        check("rst_eng_b0", 32'(eng_b0), 32'h400000);
        check("rst_eng_b1_a2", 32'(eng_b1 | eng_b2 | eng_a1 | eng_a2), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        @(posedge clk);
        #1;

        // Pass-through cascade and latency
        exp_q.push_back(24'h100000);
        push_secs(4);
        send(24'h100000, t);
        wait_mvalid(c);
        check("t1_latency", 32'(c - t), 32'd13);
        wait_idle();

        // b0=0.5 everywhere, committed while idle
        for (int s = 0; s < 4; s++) cfg_write(3'(s), 3'd0, 24'h200000);
        pulse_commit();
        @(negedge clk);
        check("t2_copy_cycle_s_ready", 32'(sif.s_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t2_after_copy_s_ready", 32'(sif.s_ready), 32'd1);
        check("t2_active_b0", 32'(eng_b0), 32'h200000);
        @(posedge clk);
        #1;
        exp_q.push_back(24'h040000);
        push_secs(4);
        send(24'h400000, t);
        wait_idle();

        // Output back-pressure
        sif.m_ready = 1'b0;
        exp_q.push_back(24'h020000);
        push_secs(4);
        send(24'h200000, t);
        wait_mvalid(c);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("t3_hold_m_valid", 32'(sif.m_valid), 32'd1);
            check("t3_hold_m_data", 32'(sif.m_data), 32'h020000);
            check("t3_hold_s_ready", 32'(sif.s_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        sif.m_ready = 1'b1;
        @(negedge clk);
        check("t3_handshake_s_ready", 32'(sif.s_ready), 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("t3_after_s_ready", 32'(sif.s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset during section 2 wait
        push_secs(3);
        send(24'h300000, t);
        wait_issue(3'd2);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t4_busy", 32'(busy), 32'd0);
        check("t4_m_valid", 32'(sif.m_valid), 32'd0);
        check("t4_m_data", 32'(sif.m_data), 32'd0);
        check("t4_eng_valid_in", 32'(eng_valid_in), 32'd0);
        check("t4_eng_sec", 32'(eng_sec), 32'd0);
        check("t4_eng_data_in", 32'(eng_data_in), 32'd0);
        check("t4_eng_b0", 32'(eng_b0), 32'h400000);
        check("t4_s_ready", 32'(sif.s_ready), 32'd1);
        @(posedge clk);
        #1;
        repeat (20) @(posedge clk);
        #1;

        // Commit arriving mid-sequence only affects the next sample
        exp_q.push_back(24'h250000);
        push_secs(4);
        send(24'h250000, t);
        wait_issue(3'd1);
        pulse_commit();
        for (int s = 0; s < 4; s++) cfg_write(3'(s), 3'd0, 24'h200000);
        wait_idle();
        exp_q.push_back(24'h040000);
        push_secs(4);
        send(24'h400000, t);
        wait_idle();

`ifdef SOS_SCHED_TIMEOUT_EN
        // Silent engine
        eng_on = 1'b0;
        push_secs(1);
        send(24'h111111, t);
        c = -1;
        for (int i = 0; i < 60 && c < 0; i++) begin
            @(negedge clk);
            if (err) begin
                c = cyc;
                check("t6_busy", 32'(busy), 32'd0);
                check("t6_m_valid", 32'(sif.m_valid), 32'd0);
            end
            @(posedge clk);
            #1;
        end
        if (c < 0) bound_fail("t6_err");
        else check("t6_err_cycle", 32'(c - t), 32'd17);
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("t6_err_cleared", 32'(err), 32'd0);
        @(posedge clk);
        #1;
        eng_on = 1'b1;
`else
        err_clr = 1'b1;
        @(posedge clk);
        #1 err_clr = 1'b0;
        @(negedge clk);
        check("t6_err_tied", 32'(err), 32'd0);
        @(posedge clk);
        #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("end_out_queue_empty", 32'(exp_q.size()), 32'd0);
        check("end_sec_queue_empty", 32'(sec_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
